cdb_broadcast: RTL and testbench

CDB_BROADCAST -- requirements
Module: cdb_broadcast

---
 rtl/cdb_broadcast.sv | 129 ++++++++++++
 tb/tb_cdb_broadcast.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcast.sv
// Common data bus arbiter: merges ALU and load-unit results into a FIFO and
// broadcasts one {tag,value} per cycle from registered outputs.
module cdb_broadcast #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       alu_valid,
  input  logic [4:0]                 alu_tag,
  input  logic [W-1:0]               alu_value,
  output logic                       alu_ready,
  input  logic                       mem_valid,
  input  logic [4:0]                 mem_tag,
  input  logic [W-1:0]               mem_value,
  output logic                       mem_ready,
  output logic                       cdb_valid,
  output logic [4:0]                 cdb_tag,
  output logic [W-1:0]               cdb_value,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       tag_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_ZERO = {(AW+1){1'b0}};
  localparam logic [AW:0] CNT_M1   = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] CNT_M2   = (AW+1)'(DEPTH - 2);

  logic [4:0]    tag_mem_r [DEPTH];
  logic [W-1:0]  val_mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [AW:0]   count_r;
  logic          cdb_valid_r;
  logic [4:0]    cdb_tag_r;
  logic [W-1:0]  cdb_value_r;
  logic          tag_err_r;

  logic          alu_push_s;
  logic          mem_push_s;
  logic          alu_bad_s;
  logic          mem_bad_s;
  logic          pop_s;
  logic [AW-1:0] mem_wr_ptr_s;
  logic [AW-1:0] wr_ptr_next_s;
  logic [AW:0]   count_next_s;

  // Readiness from the registered count only; the ALU has priority on the last slot
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (flush) begin
      alu_ready = 1'b0;
      mem_ready = 1'b0;
    end else begin
      alu_ready = (count_r <= CNT_M1);
      mem_ready = (count_r <= CNT_M2) || ((count_r == CNT_M1) && !alu_valid);
    end
  end

  // Push/pop decode; tag-0 results are accepted but dropped
  always_comb begin
    alu_push_s    = alu_valid && alu_ready && (alu_tag != 5'd0);
    mem_push_s    = mem_valid && mem_ready && (mem_tag != 5'd0);
    alu_bad_s     = alu_valid && alu_ready && (alu_tag == 5'd0);
    mem_bad_s     = mem_valid && mem_ready && (mem_tag == 5'd0);
    pop_s         = (count_r != CNT_ZERO) && !flush;
    mem_wr_ptr_s  = wr_ptr_r + AW'(alu_push_s);
    wr_ptr_next_s = wr_ptr_r + AW'(alu_push_s) + AW'(mem_push_s);
    count_next_s  = count_r + (AW+1)'(alu_push_s) + (AW+1)'(mem_push_s)
                    - (AW+1)'(pop_s);
  end

  // Queue storage: ALU entry lands first, load entry in the following slot
  always_ff @(posedge clk) begin
    if (alu_push_s) begin
      tag_mem_r[wr_ptr_r] <= alu_tag;
      val_mem_r[wr_ptr_r] <= alu_value;
    end
    if (mem_push_s) begin
      tag_mem_r[mem_wr_ptr_s] <= mem_tag;
      val_mem_r[mem_wr_ptr_s] <= mem_value;
    end
  end

  // Pointers, occupancy, broadcast register and sticky tag error
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= CNT_ZERO;
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= 5'd0;
      cdb_value_r <= {W{1'b0}};
      tag_err_r   <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= {AW{1'b0}};
      rd_ptr_r    <= {AW{1'b0}};
      count_r     <= CNT_ZERO;
      cdb_valid_r <= 1'b0;
      cdb_tag_r   <= 5'd0;
      cdb_value_r <= {W{1'b0}};
    end else begin
      wr_ptr_r <= wr_ptr_next_s;
      count_r  <= count_next_s;
      if (pop_s) begin
        rd_ptr_r    <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
        cdb_valid_r <= 1'b1;
        cdb_tag_r   <= tag_mem_r[rd_ptr_r];
        cdb_value_r <= val_mem_r[rd_ptr_r];
      end else begin
        cdb_valid_r <= 1'b0;
        cdb_tag_r   <= 5'd0;
        cdb_value_r <= {W{1'b0}};
      end
      if (alu_bad_s || mem_bad_s) begin
        tag_err_r <= 1'b1;
      end
    end
  end

  assign cdb_valid = cdb_valid_r;
  assign cdb_tag   = cdb_tag_r;
  assign cdb_value = cdb_value_r;
  assign level     = count_r;
  assign tag_err   = tag_err_r;

endmodule

// File: tb/tb_cdb_broadcast.sv
// Scoreboard bench for cdb_broadcast: accepted results are queued by the bench
// and compared against each broadcast; readiness follows the bench's own count.
module tb_cdb_broadcast;

  localparam int DEPTH = 4;
  localparam int W     = 32;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         alu_valid;
  logic [4:0]   alu_tag;
  logic [W-1:0] alu_value;
  logic         alu_ready;
  logic         mem_valid;
  logic [4:0]   mem_tag;
  logic [W-1:0] mem_value;
  logic         mem_ready;
  logic         cdb_valid;
  logic [4:0]   cdb_tag;
  logic [W-1:0] cdb_value;
  logic [2:0]   level;
  logic         tag_err;

  int n_checks = 0;
  int n_errors = 0;

  logic [36:0] sb[$];
  logic        m_err;

  cdb_broadcast #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alu_valid(alu_valid), .alu_tag(alu_tag), .alu_value(alu_value), .alu_ready(alu_ready),
    .mem_valid(mem_valid), .mem_tag(mem_tag), .mem_value(mem_value), .mem_ready(mem_ready),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .level(level), .tag_err(tag_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock cycle: drive, check readiness, clock, update model, check outputs.
  task automatic step(input logic fl, input logic av, input logic [4:0] at, input logic [31:0] avl,
                      input logic mv, input logic [4:0] mt, input logic [31:0] mvl);
    int cnt;
    logic ear, emr;
    logic [36:0] head;
    logic ev;
    logic [4:0] et;
    logic [31:0] evl;
    flush = fl; alu_valid = av; alu_tag = at; alu_value = avl;
    mem_valid = mv; mem_tag = mt; mem_value = mvl;
    #1;
    cnt = sb.size();
    ear = !fl && (cnt <= DEPTH - 1);
    emr = !fl && ((cnt <= DEPTH - 2) || ((cnt == DEPTH - 1) && !av));
    check("alu_ready", {63'd0, alu_ready}, {63'd0, ear});
    check("mem_ready", {63'd0, mem_ready}, {63'd0, emr});
    @(posedge clk);
    ev = 1'b0; et = 5'd0; evl = 32'd0;
    if (fl) begin
      sb.delete();
    end else begin
      if (sb.size() > 0) begin
        head = sb.pop_front();
        ev = 1'b1; et = head[36:32]; evl = head[31:0];
      end
      if (av && ear) begin
        if (at == 5'd0) m_err = 1'b1; else sb.push_back({at, avl});
      end
      if (mv && emr) begin
        if (mt == 5'd0) m_err = 1'b1; else sb.push_back({mt, mvl});
      end
    end
    #1;
    check("cdb_valid", {63'd0, cdb_valid}, {63'd0, ev});
    check("cdb_tag", {59'd0, cdb_tag}, {59'd0, et});
    check("cdb_value", {32'd0, cdb_value}, {32'd0, evl});
    check("level", {61'd0, level}, 64'(sb.size()));
    check("tag_err", {63'd0, tag_err}, {63'd0, m_err});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, {63'd0, cdb_valid}, 64'd0);
    check({tag, "_tag"}, {59'd0, cdb_tag}, 64'd0);
    check({tag, "_value"}, {32'd0, cdb_value}, 64'd0);
    check({tag, "_level"}, {61'd0, level}, 64'd0);
    check({tag, "_tag_err"}, {63'd0, tag_err}, 64'd0);
    check({tag, "_alu_ready"}, {63'd0, alu_ready}, 64'd1);
    check({tag, "_mem_ready"}, {63'd0, mem_ready}, 64'd1);
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0;
    alu_valid = 1'b0; alu_tag = 5'd0; alu_value = 32'd0;
    mem_valid = 1'b0; mem_tag = 5'd0; mem_value = 32'd0;
    m_err = 1'b0;
    #2;
    check_reset_state("rst");
    @(posedge clk); @(posedge clk);
    #1 rst = 1'b1;

    // Single result, latency and one-cycle broadcast
    step(1'b0, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0);
    idle(3);

    // Simultaneous ALU + load, ALU first
    step(1'b0, 1'b1, 5'd3, 32'h3333, 1'b1, 5'd7, 32'h7777);
    idle(3);

    // Saturation: both sources every cycle
    for (int i = 0; i < 10; i++)
      step(1'b0, 1'b1, 5'($urandom_range(1, 31)), $urandom,
           1'b1, 5'($urandom_range(1, 31)), $urandom);
    idle(6);

    // Flush with three entries queued, then a lone result
    step(1'b0, 1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);
    step(1'b0, 1'b1, 5'd4, 32'h44, 1'b1, 5'd6, 32'h66);
    step(1'b1, 1'b1, 5'd8, 32'h88, 1'b1, 5'd10, 32'haa);
    step(1'b0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'd0);
    idle(3);

    // Tag 0 result sets the sticky error
    step(1'b0, 1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'd0);
    idle(3);

    // Random traffic including flushes and tag 0
    for (int i = 0; i < 300; i++)
      step(1'b0 || ($urandom_range(0, 19) == 0), 1'($urandom_range(0, 1)),
           5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
    idle(6);

    // Asynchronous reset mid-stream with level 2 and a live broadcast
    step(1'b0, 1'b1, 5'd12, 32'hc0c0, 1'b1, 5'd13, 32'hd0d0);
    step(1'b0, 1'b1, 5'd14, 32'he0e0, 1'b0, 5'd0, 32'd0);
    flush = 1'b0; alu_valid = 1'b0; mem_valid = 1'b0;
    alu_tag = 5'd0; mem_tag = 5'd0; alu_value = 32'd0; mem_value = 32'd0;
    #2 rst = 1'b0;
    #1;
    check_reset_state("midrst");
    sb.delete();
    m_err = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    step(1'b0, 1'b1, 5'd11, 32'hbbbb, 1'b0, 5'd0, 32'd0);
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
